pkt_build: RTL and testbench

Transmit-side packet builder. It takes a header descriptor (MAC DA/SA, the same layout `pkt_parse` produces) and a payload byte stream from the packet FIFO, then emits a complete frame on the txg code/data interface: header first, then payload. Frames shorter than the minimum length can optionally be zero-padded. The block sits between the output packet FIFO and the gigabit transmit MAC.

---
 rtl/pkt_build_pkg.sv | 43 ++++
 rtl/pkt_build_sd_output.sv | 39 +++
 rtl/pkt_build.sv | 172 +++++++++++++++++
 tb/tb_pkt_build.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_build_pkg.sv
// Shared definitions for the transmit packet builder: descriptor layout, byte codes,
// and the packed code/data word carried through the txg output register.
package pkt_build_pkg;

   // Descriptor layout, identical to the one pkt_parse produces
   localparam int PAR_DATA_SZ  = 96;
   localparam int PAR_MACDA_HI = 95;
   localparam int PAR_MACDA_LO = 48;
   localparam int PAR_MACSA_HI = 47;
   localparam int PAR_MACSA_LO = 0;

   localparam logic [1:0] PCC_DATA   = 2'd0;
   localparam logic [1:0] PCC_SOP    = 2'd1;
   localparam logic [1:0] PCC_EOP    = 2'd2;
   localparam logic [1:0] PCC_BADEOP = 2'd3;

   localparam int HDR_BYTES = 12;
   localparam int CNT_W     = 6;

   localparam logic [CNT_W-1:0] CNT_ONE  = 6'd1;
   localparam logic [CNT_W-1:0] CNT_MAX  = 6'd63;
   localparam logic [CNT_W-1:0] HDR_LAST = 6'd11;

   typedef struct packed {
      logic [1:0] code;
      logic [7:0] data;
   } txg_word_t;

   // Byte counter increment that sticks at its maximum
   function automatic logic [CNT_W-1:0] count_inc(input logic [CNT_W-1:0] count);
      return (count == CNT_MAX) ? CNT_MAX : count + CNT_ONE;
   endfunction

   // Payload SOP/DATA both travel as DATA once the header has supplied the SOP
   function automatic logic [1:0] pay_code_map(input logic [1:0] code);
      logic [1:0] mapped;
      mapped = PCC_DATA;
      if (code == PCC_BADEOP || code == PCC_EOP)
         mapped = code;
      return mapped;
   endfunction

endpackage

// File: rtl/pkt_build_sd_output.sv
// Registered srdy/drdy output stage: a single holding register with full-rate
// throughput and no combinational path from p_drdy to p_data/p_srdy.
module pkt_build_sd_output
   import pkt_build_pkg::*;
#(
   parameter int WIDTH = $bits(txg_word_t)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ic_srdy,
   output logic             ic_drdy,
   input  logic [WIDTH-1:0] ic_data,
   output logic             p_srdy,
   input  logic             p_drdy,
   output logic [WIDTH-1:0] p_data
);

   logic             p_srdy_reg;
   logic [WIDTH-1:0] p_data_reg;

   // Accept whenever the register is empty or is being drained this cycle
   assign ic_drdy = !p_srdy_reg || p_drdy;

   always_ff @(posedge clk) begin
      if (reset) begin
         p_srdy_reg <= 1'b0;
         p_data_reg <= '0;
      end else if (ic_srdy && ic_drdy) begin
         p_srdy_reg <= 1'b1;
         p_data_reg <= ic_data;
      end else if (p_drdy) begin
         p_srdy_reg <= 1'b0;
      end
   end

   assign p_srdy = p_srdy_reg;
   assign p_data = p_data_reg;

endmodule

// File: rtl/pkt_build.sv
// pkt_build: emits a txg frame as 12 descriptor bytes (DA, SA) followed by payload.
// Define PKT_BUILD_PAD_EN to zero-pad frames shorter than MIN_LEN bytes.
module pkt_build
   import pkt_build_pkg::*;
#(
   parameter int MIN_LEN = 60
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   hdr_srdy,
   output logic                   hdr_drdy,
   input  logic [PAR_DATA_SZ-1:0] hdr_data,
   input  logic                   pdi_srdy,
   output logic                   pdi_drdy,
   input  logic [1:0]             pdi_code,
   input  logic [7:0]             pdi_data,
   output logic                   txg_srdy,
   input  logic                   txg_drdy,
   output logic [1:0]             txg_code,
   output logic [7:0]             txg_data
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_PAY  = 2'd2
`ifdef PKT_BUILD_PAD_EN
      , ST_PAD = 2'd3
`endif
   } state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] count_reg;
   logic [7:0]       hdr_bytes [HDR_BYTES];
   logic             ic_srdy;
   logic             ic_drdy;
   logic             ic_xfer;
   logic [1:0]       ic_code;
   logic [7:0]       ic_byte;
   logic             frame_end;
   logic             pay_short;
   txg_word_t        ic_data;
   txg_word_t        p_data;

   // Descriptor split into bytes, DA MSB first then SA MSB first
   for (genvar gi = 0; gi < HDR_BYTES; gi++) begin : g_hdr_byte
      assign hdr_bytes[gi] = hdr_data[PAR_DATA_SZ-1-8*gi -: 8];
   end

`ifdef PKT_BUILD_PAD_EN
   localparam logic [CNT_W:0] MIN_LEN_C = (CNT_W+1)'(MIN_LEN);
   logic [CNT_W:0] count_plus1;

   assign count_plus1 = {1'b0, count_reg} + {{CNT_W{1'b0}}, 1'b1};
   assign pay_short   = count_plus1 < MIN_LEN_C;
`else
   logic [31:0] unused_min_len;

   assign unused_min_len = 32'(MIN_LEN);
   assign pay_short      = 1'b0;
`endif

   // Byte 0 is offered straight from IDLE so back-to-back frames have no gap
   always_comb begin
      ic_srdy   = 1'b0;
      ic_code   = PCC_DATA;
      ic_byte   = 8'h00;
      frame_end = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            ic_srdy = hdr_srdy;
            ic_code = PCC_SOP;
            ic_byte = hdr_bytes[0];
         end
         ST_HDR: begin
            ic_srdy = 1'b1;
            ic_byte = hdr_bytes[count_reg[3:0]];
         end
         ST_PAY: begin
            ic_srdy = pdi_srdy;
            ic_byte = pdi_data;
            ic_code = pay_code_map(pdi_code);
            if (pdi_code == PCC_BADEOP) begin
               frame_end = 1'b1;
            end else if (pdi_code == PCC_EOP) begin
               if (pay_short)
                  ic_code = PCC_DATA;
               else
                  frame_end = 1'b1;
            end
         end
`ifdef PKT_BUILD_PAD_EN
         ST_PAD: begin
            ic_srdy = 1'b1;
            if (count_plus1 >= MIN_LEN_C) begin
               ic_code   = PCC_EOP;
               frame_end = 1'b1;
            end
         end
`endif
         default: ;
      endcase
   end

   assign ic_data  = '{code: ic_code, data: ic_byte};
   assign ic_xfer  = ic_srdy && ic_drdy;
   assign hdr_drdy = !reset && frame_end && ic_xfer;
   assign pdi_drdy = !reset && (state_reg == ST_PAY) && ic_drdy;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         count_reg <= '0;
      end else if (ic_xfer) begin
         case (state_reg)
            ST_IDLE: begin
               state_reg <= ST_HDR;
               count_reg <= CNT_ONE;
            end
            ST_HDR: begin
               count_reg <= count_inc(count_reg);
               if (count_reg == HDR_LAST)
                  state_reg <= ST_PAY;
            end
            ST_PAY: begin
               if (frame_end) begin
                  state_reg <= ST_IDLE;
                  count_reg <= '0;
               end
`ifdef PKT_BUILD_PAD_EN
               else begin
                  count_reg <= count_inc(count_reg);
                  if (pdi_code == PCC_EOP)
                     state_reg <= ST_PAD;
               end
`endif
            end
`ifdef PKT_BUILD_PAD_EN
            ST_PAD: begin
               if (frame_end) begin
                  state_reg <= ST_IDLE;
                  count_reg <= '0;
               end else begin
                  count_reg <= count_inc(count_reg);
               end
            end
`endif
            default: begin
               state_reg <= ST_IDLE;
               count_reg <= '0;
            end
         endcase
      end
   end

   pkt_build_sd_output #(
      .WIDTH($bits(txg_word_t))
   ) u_sd_output (
      .clk     (clk),
      .reset   (reset),
      .ic_srdy (ic_srdy),
      .ic_drdy (ic_drdy),
      .ic_data (ic_data),
      .p_srdy  (txg_srdy),
      .p_drdy  (txg_drdy),
      .p_data  (p_data)
   );

   assign txg_code = p_data.code;
   assign txg_data = p_data.data;

endmodule

// File: tb/tb_pkt_build.sv
// Scoreboard bench for pkt_build: drivers push expected txg words, a negedge monitor
// pops and compares every output transfer. Frame lengths follow PKT_BUILD_PAD_EN.
module tb_pkt_build;
   import pkt_build_pkg::*;

   localparam int MIN_LEN = 60;

   logic                   clk;
   logic                   reset;
   logic                   hdr_srdy;
   logic                   hdr_drdy;
   logic [PAR_DATA_SZ-1:0] hdr_data;
   logic                   pdi_srdy;
   logic                   pdi_drdy;
   logic [1:0]             pdi_code;
   logic [7:0]             pdi_data;
   logic                   txg_srdy;
   logic                   txg_drdy;
   logic [1:0]             txg_code;
   logic [7:0]             txg_data;

   pkt_build #(.MIN_LEN(MIN_LEN)) dut (
      .clk      (clk),
      .reset    (reset),
      .hdr_srdy (hdr_srdy),
      .hdr_drdy (hdr_drdy),
      .hdr_data (hdr_data),
      .pdi_srdy (pdi_srdy),
      .pdi_drdy (pdi_drdy),
      .pdi_code (pdi_code),
      .pdi_data (pdi_data),
      .txg_srdy (txg_srdy),
      .txg_drdy (txg_drdy),
      .txg_code (txg_code),
      .txg_data (txg_data)
   );

   logic [9:0]  exp_q [$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          last_xfer = 0;
   int          n_xfer = 0;
   int          n_hdr_pulse = 0;
   bit          strict = 0;
   bit          bp_mode = 0;
   bit          gaps = 0;
   bit          abort = 0;
   bit          hold_prev = 0;
   logic [9:0]  hold_val;
   logic [95:0] desc [4];
   logic [7:0]  pay_data [256];
   logic [1:0]  pay_code [256];
   int          pay_idx = -1;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // MAC ready: always high, or a coin toss per cycle under backpressure
   initial begin
      txg_drdy = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         txg_drdy = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: every transfer is popped against the scoreboard
   always @(negedge clk) begin
      logic [9:0] e;
      cyc++;
      if (hold_prev && !reset)
         check("txg_stable", {22'd0, txg_srdy, txg_code, txg_data}, {22'd0, 1'b1, hold_val});
      hold_prev = txg_srdy && !txg_drdy && !reset;
      hold_val  = {txg_code, txg_data};
      if (hdr_drdy === 1'b1)
         n_hdr_pulse++;
      if (txg_srdy === 1'b1 && txg_drdy === 1'b1) begin
         n_xfer++;
         $display("xfer cyc=%0d code=%0d data=%02h", cyc, txg_code, txg_data);
         if (strict)
            check("no_bubble_cycle", 32'(cyc), 32'(last_xfer + 1));
         last_xfer = cyc;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL txg_byte: got %0h want nothing queued", {txg_code, txg_data});
         end else begin
            e = exp_q.pop_front();
            check("txg_byte", 32'({txg_code, txg_data}), 32'(e));
         end
      end
   end

   // Builds descriptor f and its payload, and queues the frame the MAC must see
   task automatic build_frame(input int f, input logic [47:0] da, input logic [47:0] sa,
                              input int start, input int len, input logic [1:0] last_code,
                              input logic [7:0] seed);
      logic [95:0] hd;
      logic [1:0]  c;
      int          flen;
      hd = {da, sa};
      desc[f] = hd;
      flen = HDR_BYTES + len;
      for (int i = 0; i < HDR_BYTES; i++)
         exp_q.push_back({(i == 0) ? PCC_SOP : PCC_DATA, hd[95-8*i -: 8]});
      for (int i = 0; i < len; i++) begin
         if (i == len - 1)      c = last_code;
         else if (i == 0)       c = PCC_SOP;
         else                   c = PCC_DATA;
         pay_code[start+i] = c;
         pay_data[start+i] = seed + 8'(i);
         if (c == PCC_BADEOP)
            exp_q.push_back({PCC_BADEOP, pay_data[start+i]});
         else if (c == PCC_EOP) begin
`ifdef PKT_BUILD_PAD_EN
            exp_q.push_back({(flen < MIN_LEN) ? PCC_DATA : PCC_EOP, pay_data[start+i]});
`else
            exp_q.push_back({PCC_EOP, pay_data[start+i]});
`endif
         end else
            exp_q.push_back({PCC_DATA, pay_data[start+i]});
      end
`ifdef PKT_BUILD_PAD_EN
      if (last_code == PCC_EOP)
         for (int k = flen; k < MIN_LEN; k++)
            exp_q.push_back({(k == MIN_LEN - 1) ? PCC_EOP : PCC_DATA, 8'h00});
`endif
   endtask

   task automatic drive_hdrs(input int nfr);
      bit acc;
      int w;
      for (int f = 0; f < nfr && !abort; f++) begin
         hdr_srdy = 1'b1;
         hdr_data = desc[f];
         acc = 1'b0;
         w = 0;
         while (!acc && !abort && w < 3000) begin
            @(negedge clk);
            acc = hdr_drdy;
            @(posedge clk);
            #1;
            w++;
         end
         if (!acc && !abort) begin
            n_cmp++;
            n_err++;
            $display("FAIL hdr_drdy_timeout: got no pulse want pulse for frame %0d", f);
         end
      end
      hdr_srdy = 1'b0;
   endtask

   task automatic drive_pay(input int total);
      bit acc;
      int w;
      for (int i = 0; i < total && !abort; i++) begin
         if (gaps && (i % 3 == 1)) begin
            pdi_srdy = 1'b0;
            @(posedge clk);
            #1;
         end
         pay_idx  = i;
         pdi_srdy = 1'b1;
         pdi_code = pay_code[i];
         pdi_data = pay_data[i];
         acc = 1'b0;
         w = 0;
         while (!acc && !abort && w < 3000) begin
            @(negedge clk);
            acc = pdi_drdy;
            @(posedge clk);
            #1;
            w++;
         end
         if (!acc && !abort) begin
            n_cmp++;
            n_err++;
            $display("FAIL pdi_drdy_timeout: got no accept want accept of byte %0d", i);
         end
      end
      pdi_srdy = 1'b0;
   endtask

   task automatic run_test(input string name, input int nfr, input int total, input int exp_len,
                           input bit bp, input bit gp, input bit st);
      int w;
      n_xfer = 0;
      n_hdr_pulse = 0;
      bp_mode = bp;
      gaps = gp;
      strict = st;
      last_xfer = cyc + 1;
      fork
         drive_hdrs(nfr);
         drive_pay(total);
      join
      w = 0;
      while (exp_q.size() != 0 && w < 3000) begin
         @(posedge clk);
         #1;
         w++;
      end
      strict = 0;
      bp_mode = 0;
      repeat (4) @(posedge clk);
      #1;
      check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
      check({name, "_len"}, 32'(n_xfer), 32'(exp_len));
      check({name, "_hdr_drdy_pulses"}, 32'(n_hdr_pulse), 32'(nfr));
      exp_q.delete();
   endtask

   task automatic reset_at_byte20();
      int w;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (pay_idx != 20 && w < 2000);
      if (pay_idx != 20) begin
         n_cmp++;
         n_err++;
         $display("FAIL reset_wait_timeout: got pay_idx %0d want 20", pay_idx);
      end
      reset = 1'b1;
      abort = 1'b1;
      @(negedge clk);
      check("reset_mid_txg_srdy", 32'(txg_srdy), 32'd0);
      check("reset_mid_pdi_drdy", 32'(pdi_drdy), 32'd0);
      check("reset_mid_hdr_drdy", 32'(hdr_drdy), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      hdr_srdy = 1'b0;
      hdr_data = '0;
      pdi_srdy = 1'b0;
      pdi_code = PCC_DATA;
      pdi_data = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_txg_srdy", 32'(txg_srdy), 32'd0);
      check("reset_hdr_drdy", 32'(hdr_drdy), 32'd0);
      check("reset_pdi_drdy", 32'(pdi_drdy), 32'd0);
      check("reset_txg_code", 32'(txg_code), 32'd0);
      check("reset_txg_data", 32'(txg_data), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      build_frame(0, 48'h001122334455, 48'h66778899AABB, 0, 50, PCC_EOP, 8'h40);
      run_test("basic", 1, 50, 62, 1'b0, 1'b0, 1'b1);

      build_frame(0, 48'h0A1B2C3D4E5F, 48'h111213141516, 0, 10, PCC_EOP, 8'hC0);
`ifdef PKT_BUILD_PAD_EN
      run_test("short", 1, 10, 60, 1'b0, 1'b0, 1'b1);
`else
      run_test("short", 1, 10, 22, 1'b0, 1'b0, 1'b1);
`endif

      build_frame(0, 48'hFFEEDDCCBBAA, 48'h998877665544, 0, 5, PCC_BADEOP, 8'hE0);
      run_test("bad", 1, 5, 17, 1'b0, 1'b0, 1'b1);

      build_frame(0, 48'h001122334455, 48'h66778899AABB, 0, 50, PCC_EOP, 8'h40);
      run_test("backpressure", 1, 50, 62, 1'b1, 1'b1, 1'b0);

      build_frame(0, 48'h020406080A0C, 48'h030507090B0D, 0, 8, PCC_EOP, 8'h10);
      build_frame(1, 48'hA0A1A2A3A4A5, 48'hB0B1B2B3B4B5, 8, 50, PCC_EOP, 8'h70);
`ifdef PKT_BUILD_PAD_EN
      run_test("b2b", 2, 58, 122, 1'b0, 1'b0, 1'b1);
`else
      run_test("b2b", 2, 58, 82, 1'b0, 1'b0, 1'b1);
`endif

      n_xfer = 0;
      n_hdr_pulse = 0;
      pay_idx = -1;
      build_frame(0, 48'h0A0B0C0D0E0F, 48'h102030405060, 0, 40, PCC_EOP, 8'h80);
      fork
         drive_hdrs(1);
         drive_pay(40);
         reset_at_byte20();
      join
      abort = 1'b0;
      exp_q.delete();
      check("reset_mid_xfers", 32'(n_xfer), 32'd32);
      check("reset_mid_hdr_drdy_pulses", 32'(n_hdr_pulse), 32'd0);
      repeat (2) @(posedge clk);
      #1;

      build_frame(0, 48'h5A5A5A5A5A5A, 48'hA5A5A5A5A5A5, 0, 48, PCC_EOP, 8'h20);
      run_test("after_reset", 1, 48, 60, 1'b0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
